// File: rtl/sum_pair_driver_if.sv
// sum_pair_driver_if: valid/ready push channel carrying one a/b operand pair per transfer.
interface sum_pair_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  modport master (output in_valid, in_a, in_b, input in_ready);
  modport slave (input in_valid, in_a, in_b, output in_ready);
endinterface

// File: rtl/sum_pair_driver.sv
// sum_pair_driver: buffers operand pairs, drives them into the dual-sum datapath and checks z0/z1.
module sum_pair_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_,
  sum_pair_driver_if.slave   push_if,
  input  logic               clr,
  output logic [7:0]         a,
  output logic [7:0]         b,
  output logic [2:0]         c,
  output logic [5:0]         d,
  input  logic [7:0]         z0,
  input  logic [7:0]         z1,
  output logic               busy,
  output logic               err,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [7:0]         last_fail_a,
  output logic [7:0]         last_fail_b
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
  state_t      state, state_nxt;
  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop, match;
  logic [8:0]  sum;
  // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_if.in_ready = !full;
  assign push = push_if.in_valid && !full;
  assign pop = (state == IDLE) && !empty;
  assign busy = (state != IDLE) || !empty;
  assign sum = {1'b0, a} + {1'b0, b};
  assign match = (z0 == sum[7:0]) && (z1 == 8'(sum + 9'd1));
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (empty ? IDLE : ISSUE) : (state == ISSUE) ? CHECK : IDLE;
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {push_if.in_a, push_if.in_b};
  // a/b stay held through CHECK since z1 reloads every cycle with d fixed at 0.
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      a <= '0;
      b <= '0;
      c <= 3'd7;
      d <= '0;
    end else begin
      d <= '0;
      if (pop) begin
        {a, b} <= mem[rd_ptr[AW-1:0]];
        c      <= 3'd0;
      end else if (state == ISSUE) begin
        c <= 3'd7;
      end
    end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      err         <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      last_fail_a <= '0;
      last_fail_b <= '0;
    end else if (clr) begin
      err         <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      last_fail_a <= '0;
      last_fail_b <= '0;
    end else if (state == CHECK) begin
      if (match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
        err         <= 1'b1;
        last_fail_a <= a;
        last_fail_b <= b;
      end
    end
endmodule

// File: tb/tb_sum_pair_driver.sv
// tb_sum_pair_driver: drives operand pairs into two driver instances backed by behavioural datapaths.
module tb_sum_pair_driver;
  logic clk = 0, reset_ = 1, clr = 0, clr2 = 0;
  always #5 clk = ~clk;
  sum_pair_driver_if pif ();
  sum_pair_driver_if pif2 ();
  logic [7:0] a, b, z0, z1, lfa, lfb, pass_cnt, fail_cnt;
  logic [2:0] c;
  logic [5:0] d;
  logic busy, err;
  logic [7:0] a2, b2, z0_2, z1_2, lfa2, lfb2;
  logic [1:0] pass2, fail2;
  logic [2:0] c2;
  logic [5:0] d2;
  logic busy2, err2;
  int checks = 0, errors = 0;
  bit fault = 0;
  logic [15:0] issued[$];
  logic [15:0] obs_z[$];
  bit prev_c0 = 0;
  int accepted = 0, occ_at_full = -1;
  sum_pair_driver #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset_(reset_), .push_if(pif), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .z0(z0), .z1(z1), .busy(busy), .err(err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .last_fail_a(lfa), .last_fail_b(lfb));
  sum_pair_driver #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_(reset_), .push_if(pif2), .clr(clr2), .a(a2), .b(b2), .c(c2), .d(d2),
    .z0(z0_2), .z1(z1_2), .busy(busy2), .err(err2), .pass_cnt(pass2), .fail_cnt(fail2),
    .last_fail_a(lfa2), .last_fail_b(lfb2));
  // Registered dual-sum datapaths; the second one always returns a wrong z1.
  always @(posedge clk or negedge reset_)
    if (!reset_) begin
      z0 <= '0; z1 <= '0; z0_2 <= '0; z1_2 <= '0;
    end else begin
      if (c < 3'd2) z0 <= 8'(a + b);
      if (d < 6'd63 || d == 6'd63) z1 <= 8'(a + b + 8'd1 + 8'(fault));
      if (c2 < 3'd2) z0_2 <= 8'(a2 + b2);
      z1_2 <= 8'(a2 + b2 + 8'd2);
    end
  always @(negedge clk) begin
    if (prev_c0) obs_z.push_back({z0, z1});
    if (c == 3'd0) issued.push_back({a, b});
    prev_c0 = (c == 3'd0);
    if (!pif.in_ready && occ_at_full < 0) occ_at_full = accepted - issued.size();
  end
  task automatic push(input bit sel, input logic [7:0] pa, input logic [7:0] pb);
    int n = 0;
    if (sel) begin pif2.in_valid = 1; pif2.in_a = pa; pif2.in_b = pb; end
    else begin pif.in_valid = 1; pif.in_a = pa; pif.in_b = pb; end
    while (!(sel ? pif2.in_ready : pif.in_ready) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL push_timeout in_ready stuck low after %0d cycles, required high", n); end
    @(posedge clk); #1;
    if (!sel) accepted++;
    pif.in_valid = 0; pif2.in_valid = 0;
  endtask
  task automatic wait_idle(input bit sel);
    int n = 0;
    while ((sel ? busy2 : busy) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL idle_timeout busy still 1 after %0d cycles, required 0", n); end
  endtask
  task automatic test_reset();
    #2 reset_ = 0;
    #1;
    checks++;
    if ({a, b, c, d} !== {8'd0, 8'd0, 3'd7, 6'd0}) begin
      errors++; $display("FAIL reset_abcd got a=%0d b=%0d c=%0d d=%0d required 0 0 7 0", a, b, c, d);
    end
    checks++;
    if ({err, pass_cnt, fail_cnt, lfa, lfb, busy} !== '0) begin
      errors++; $display("FAIL reset_status got err=%0d pass=%0d fail=%0d lfa=%0d lfb=%0d busy=%0d required all 0",
        err, pass_cnt, fail_cnt, lfa, lfb, busy);
    end
    repeat (2) @(posedge clk);
    #1 reset_ = 1;
    @(posedge clk); #1;
    checks++;
    if (pif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d required 1", pif.in_ready); end
  endtask
  task automatic test_basic();
    issued.delete(); obs_z.delete();
    pif.in_valid = 1; pif.in_a = 8'd3; pif.in_b = 8'd5;
    @(posedge clk); #1;
    accepted++;
    pif.in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (pass_cnt !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_early got pass=%0d busy=%0d required 0 1", pass_cnt, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (pass_cnt !== 8'd1 || err !== 1'b0 || fail_cnt !== 8'd0) begin
      errors++; $display("FAIL basic_latency got pass=%0d fail=%0d err=%0d required 1 0 0", pass_cnt, fail_cnt, err);
    end
    checks++;
    if (obs_z.size() != 1 || obs_z[0] !== {8'd8, 8'd9}) begin
      errors++; $display("FAIL basic_z got n=%0d z=%h required 1 0809", obs_z.size(), obs_z.size() ? obs_z[0] : 16'hxxxx);
    end
  endtask
  task automatic test_wrap();
    obs_z.delete();
    push(0, 8'd255, 8'd1);
    wait_idle(0);
    checks++;
    if (pass_cnt !== 8'd2 || fail_cnt !== 8'd0) begin
      errors++; $display("FAIL wrap_cnt got pass=%0d fail=%0d required 2 0", pass_cnt, fail_cnt);
    end
    checks++;
    if (obs_z.size() != 1 || obs_z[0] !== {8'd0, 8'd1}) begin
      errors++; $display("FAIL wrap_z got n=%0d z=%h required 1 0001", obs_z.size(), obs_z.size() ? obs_z[0] : 16'hxxxx);
    end
  endtask
  task automatic test_fault();
    fault = 1;
    push(0, 8'd10, 8'd20);
    wait_idle(0);
    fault = 0;
    checks++;
    if (fail_cnt !== 8'd1 || err !== 1'b1 || lfa !== 8'd10 || lfb !== 8'd20 || pass_cnt !== 8'd2) begin
      errors++; $display("FAIL fault_capture got fail=%0d err=%0d lfa=%0d lfb=%0d pass=%0d required 1 1 10 20 2",
        fail_cnt, err, lfa, lfb, pass_cnt);
    end
    clr = 1; @(posedge clk); #1; clr = 0;
    checks++;
    if ({pass_cnt, fail_cnt, err, lfa, lfb} !== '0) begin
      errors++; $display("FAIL clr_all got pass=%0d fail=%0d err=%0d lfa=%0d lfb=%0d required all 0",
        pass_cnt, fail_cnt, err, lfa, lfb);
    end
    push(0, 8'd7, 8'd9);
    repeat (2) begin @(posedge clk); #1; end
    clr = 1; @(posedge clk); #1; clr = 0;
    checks++;
    if (pass_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_wins got pass=%0d busy=%0d required 0 0", pass_cnt, busy);
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] sent[$];
    issued.delete(); obs_z.delete();
    accepted = 0; occ_at_full = -1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] pa, pb;
      pa = 8'($urandom); pb = 8'($urandom);
      sent.push_back({pa, pb});
      push(0, pa, pb);
    end
    wait_idle(0);
    checks++;
    if (occ_at_full != 4) begin errors++; $display("FAIL b2b_full_occupancy got %0d required 4", occ_at_full); end
    checks++;
    if (issued.size() != 6) begin errors++; $display("FAIL b2b_issue_count got %0d required 6", issued.size()); end
    for (int i = 0; i < 6 && i < issued.size() && i < obs_z.size(); i++) begin
      logic [7:0] s0, s1;
      s0 = 8'(sent[i][15:8] + sent[i][7:0]);
      s1 = 8'(s0 + 8'd1);
      checks++;
      if (issued[i] !== sent[i] || obs_z[i] !== {s0, s1}) begin
        errors++; $display("FAIL b2b_pair%0d got ab=%h z=%h required ab=%h z=%h", i, issued[i], obs_z[i], sent[i], {s0, s1});
      end
    end
    checks++;
    if (pass_cnt !== 8'd6 || fail_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_final got pass=%0d fail=%0d busy=%0d required 6 0 0", pass_cnt, fail_cnt, busy);
    end
  endtask
  task automatic test_saturate();
    int n = 5, exp_fail;
    logic [7:0] la = 0, lb = 0;
    exp_fail = n > 3 ? 3 : n;
    for (int i = 0; i < n; i++) begin
      la = 8'($urandom); lb = 8'($urandom);
      push(1, la, lb);
    end
    wait_idle(1);
    checks++;
    if (fail2 !== 2'(exp_fail) || err2 !== 1'b1 || pass2 !== 2'd0) begin
      errors++; $display("FAIL sat_cnt got fail=%0d err=%0d pass=%0d required %0d 1 0", fail2, err2, pass2, exp_fail);
    end
    checks++;
    if (lfa2 !== la || lfb2 !== lb) begin
      errors++; $display("FAIL sat_last got %0d/%0d required %0d/%0d", lfa2, lfb2, la, lb);
    end
  endtask
  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) push(0, 8'(i + 1), 8'(i + 2));
    checks++;
    if (c !== 3'd7 || a !== 8'd1 || pass_cnt !== 8'd6) begin
      errors++; $display("FAIL midop_in_check got c=%0d a=%0d pass=%0d required 7 1 6", c, a, pass_cnt);
    end
    reset_ = 0;
    #1;
    checks++;
    if ({a, b, c, d, busy, pif.in_ready, pass_cnt, err} !== {8'd0, 8'd0, 3'd7, 6'd0, 1'b0, 1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL midop_reset got a=%0d b=%0d c=%0d d=%0d busy=%0d rdy=%0d pass=%0d err=%0d required 0 0 7 0 0 1 0 0",
        a, b, c, d, busy, pif.in_ready, pass_cnt, err);
    end
    @(posedge clk); #1;
    reset_ = 1;
    issued.delete();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (issued.size() != 0 || busy !== 1'b0 || pass_cnt !== 8'd0) begin
      errors++; $display("FAIL midop_after got issues=%0d busy=%0d pass=%0d required 0 0 0", issued.size(), busy, pass_cnt);
    end
  endtask
  initial begin
    pif.in_valid = 0; pif.in_a = 0; pif.in_b = 0;
    pif2.in_valid = 0; pif2.in_a = 0; pif2.in_b = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_back_to_back();
    test_saturate();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
